// File: rtl/vsa_mem_arbiter.sv
// vsa_mem_arbiter: shares one single-ported memory between the instruction
// fetch port (IF, read-only) and the data port (D, loads and stores).
// One access is in flight at a time. The memory strobe, the response data and
// the acks are all registered. Ties are broken round-robin, or always in
// favour of IF when FIXED_PRI is set.
module vsa_mem_arbiter #(
    parameter int AW        = 5,
    parameter int DW        = 12,
    parameter int MEM_LAT   = 1,
    parameter int FIXED_PRI = 0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [4:0]    d_wdata,
    output logic          d_ack,
    output logic [4:0]    d_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Latency counter preload; MEM_LAT is limited to 1..4, so 3 bits suffice.
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            grant_q, grant_d;         // grantee of the current access: 1 = D port
    logic            wr_q, wr_d;               // current access is a store
    logic            last_d_q, last_d_d;       // round-robin pointer: 1 = D was granted last
    logic            mem_en_q, mem_en_d;
    logic            mem_wr_q, mem_wr_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            if_ack_q, if_ack_d;
    logic            d_ack_q, d_ack_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [4:0]      d_rdata_q, d_rdata_d;
    logic            pick_d;

    // D wins only when it is alone, or on a tie when IF was served last.
    assign pick_d = d_req && (!if_req || ((FIXED_PRI == 0) && !last_d_q));

    // State register; reset drops any access in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (if_req || d_req) state_d = ACCESS;
            ACCESS:  state_d = WAIT;
            WAIT:    if (cnt_q == 3'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered below.
    always_comb begin
        grant_d     = grant_q;
        wr_d        = wr_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // IF is read-only, so d_wr only matters when D is granted.
                    grant_d     = pick_d;
                    wr_d        = pick_d & d_wr;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = pick_d & d_wr;
                    mem_addr_d  = pick_d ? d_addr : if_addr;
                    mem_wdata_d = (pick_d & d_wr) ? {{(DW-5){1'b0}}, d_wdata} : '0;
                end
            end
            ACCESS: begin
                cnt_d = LAT_INIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // cnt_q == 1 marks the cycle in which mem_rdata is valid.
                if (cnt_q == 3'd1) begin
                    if (grant_q) begin
                        d_ack_d = 1'b1;
                        if (!wr_q) d_rdata_d = mem_rdata[4:0];
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                last_d_d = grant_q;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            wr_q        <= 1'b0;
            last_d_q    <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            wr_q        <= wr_d;
            last_d_q    <= last_d_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vsa_mem_arbiter.sv
// Bench for vsa_mem_arbiter. Three instances: 0 = MEM_LAT 1 round-robin,
// 1 = MEM_LAT 3 round-robin, 2 = MEM_LAT 1 fixed IF priority. A small memory
// model returns data exactly MEM_LAT cycles after the strobe and garbage
// otherwise. Stimulus pushes expected strobes and acks into queues; a monitor
// pops and compares whenever a DUT strobes memory or acks.
module tb_vsa_mem_arbiter;

    localparam int N = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic        if_req    [N];
    logic [4:0]  if_addr   [N];
    logic        if_ack    [N];
    logic [11:0] if_rdata  [N];
    logic        d_req     [N];
    logic        d_wr      [N];
    logic [4:0]  d_addr    [N];
    logic [4:0]  d_wdata   [N];
    logic        d_ack     [N];
    logic [4:0]  d_rdata   [N];
    logic        mem_en    [N];
    logic        mem_wr    [N];
    logic [4:0]  mem_addr  [N];
    logic [11:0] mem_wdata [N];
    logic [11:0] mem_rdata [N];
    logic        busy      [N];

    // Fixed memory contents (hand-chosen values).
    function automatic logic [11:0] memval(input logic [4:0] a);
        case (a)
            5'h04:   return 12'h123;
            5'h06:   return 12'hA5C;
            5'h0A:   return 12'h013;
            5'h10:   return 12'h7E8;
            default: return 12'hE00;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 1) ? 3 : 1;
        localparam int FP  = (g == 2) ? 1 : 0;
        logic [2:0] dv = '0;
        logic [4:0] da [3];

        always @(posedge clock) begin
            dv    <= {dv[1:0], mem_en[g]};
            da[0] <= mem_addr[g];
            da[1] <= da[0];
            da[2] <= da[1];
        end

        assign mem_rdata[g] = dv[LAT-1] ? memval(da[LAT-1]) : 12'hBAD;

        vsa_mem_arbiter #(
            .AW(5), .DW(12), .MEM_LAT(LAT), .FIXED_PRI(FP)
        ) u_dut (
            .clock     (clock),
            .reset_n   (reset_n),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_ack    (if_ack[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_wr      (d_wr[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_ack     (d_ack[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_wr    (mem_wr[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        int          dut;
        int          port;   // 0 = IF, 1 = D
        logic [11:0] rdata;
        int          cycle;
    } ack_t;

    typedef struct {
        int          dut;
        logic        wr;
        logic [4:0]  addr;
        logic [11:0] wdata;
        int          cycle;
    } stb_t;

    ack_t ackq[$];
    stb_t stbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every strobe and ack against the queued expectations.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int g = 0; g < N; g++) begin
                if (if_ack[g] || d_ack[g]) begin
                    if (ackq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ack: dut %0d if_ack=%0b d_ack=%0b at cycle %0d, none expected",
                                 g, if_ack[g], d_ack[g], cyc);
                    end else begin
                        ack_t e;
                        e = ackq.pop_front();
                        chk("ack_dut", 32'(g), 32'(e.dut));
                        chk("ack_port", 32'({if_ack[g], d_ack[g]}), (e.port == 1) ? 32'd1 : 32'd2);
                        chk("ack_cycle", 32'(cyc), 32'(e.cycle));
                        if (e.port == 0) chk("if_rdata", 32'(if_rdata[g]), 32'(e.rdata));
                        else             chk("d_rdata", 32'(d_rdata[g]), 32'(e.rdata[4:0]));
                    end
                end
                if (mem_en[g]) begin
                    if (stbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_strobe: dut %0d addr %0h at cycle %0d, none expected",
                                 g, mem_addr[g], cyc);
                    end else begin
                        stb_t s;
                        s = stbq.pop_front();
                        chk("stb_dut", 32'(g), 32'(s.dut));
                        chk("stb_wr", 32'(mem_wr[g]), 32'(s.wr));
                        chk("stb_addr", 32'(mem_addr[g]), 32'(s.addr));
                        chk("stb_wdata", 32'(mem_wdata[g]), 32'(s.wdata));
                        chk("stb_cycle", 32'(cyc), 32'(s.cycle));
                    end
                end else begin
                    chk("mem_wr_idle", 32'(mem_wr[g]), 32'd0);
                end
            end
        end
    end

    task automatic drv_if(input int g, input logic on, input logic [4:0] a);
        if_req[g]  = on;
        if_addr[g] = a;
    endtask

    task automatic drv_d(input int g, input logic on, input logic wr,
                         input logic [4:0] a, input logic [4:0] wd);
        d_req[g]   = on;
        d_wr[g]    = wr;
        d_addr[g]  = a;
        d_wdata[g] = wd;
    endtask

    task automatic exp_ack(input int g, input int port, input logic [11:0] rd, input int c);
        ack_t e;
        e.dut = g; e.port = port; e.rdata = rd; e.cycle = c;
        ackq.push_back(e);
    endtask

    task automatic exp_stb(input int g, input logic wr, input logic [4:0] a,
                           input logic [11:0] wd, input int c);
        stb_t s;
        s.dut = g; s.wr = wr; s.addr = a; s.wdata = wd; s.cycle = c;
        stbq.push_back(s);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Bounded wait for an ack; returns just after the negedge of the ack cycle.
    task automatic wait_ack(input int g, input int port);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            #1;
            k++;
        end while (!((port == 1) ? d_ack[g] : if_ack[g]) && k < 20);
        if (!((port == 1) ? d_ack[g] : if_ack[g])) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: dut %0d port %0d no ack within 20 cycles", g, port);
        end
    endtask

    task automatic chk_reset_state(input int g);
        chk("rst_ctrl", 32'({busy[g], if_ack[g], d_ack[g], mem_en[g], mem_wr[g]}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr[g]), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata[g]), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata[g]), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata[g]), 32'd0);
    endtask

    initial begin
        int t;
        for (int g = 0; g < N; g++) begin
            drv_if(g, 1'b0, 5'h00);
            drv_d(g, 1'b0, 1'b0, 5'h00, 5'h00);
        end

        // Reset state of all instances.
        reset_n = 1'b0;
        tick(2);
        #1;
        for (int g = 0; g < N; g++) chk_reset_state(g);
        reset_n = 1'b1;

        // Reset asserted mid-WAIT on the MEM_LAT=3 instance.
        tick(1);
        t = cyc;
        drv_if(1, 1'b1, 5'h06);
        exp_stb(1, 1'b0, 5'h06, 12'h000, t + 1);
        tick(2);
        #1;
        chk("pre_rst_busy", 32'(busy[1]), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy[1]), 32'd0);
        chk("midrst_acks", 32'({if_ack[1], d_ack[1]}), 32'd0);
        chk("midrst_mem_en", 32'(mem_en[1]), 32'd0);
        drv_if(1, 1'b0, 5'h00);
        tick(1);
        reset_n = 1'b1;

        // IF read after reset release, MEM_LAT=3.
        tick(1);
        t = cyc;
        drv_if(1, 1'b1, 5'h04);
        exp_stb(1, 1'b0, 5'h04, 12'h000, t + 1);
        exp_ack(1, 0, 12'h123, t + 5);
        wait_ack(1, 0);
        drv_if(1, 1'b0, 5'h00);

        // Load with MEM_LAT=3: ack five cycles after the request.
        tick(1);
        t = cyc;
        drv_d(1, 1'b1, 1'b0, 5'h0A, 5'h00);
        exp_stb(1, 1'b0, 5'h0A, 12'h000, t + 1);
        exp_ack(1, 1, 12'h013, t + 5);
        wait_ack(1, 1);
        drv_d(1, 1'b0, 1'b0, 5'h00, 5'h00);

        // Tie after reset: IF first, then D, then the next tie goes to IF again.
        tick(1);
        t = cyc;
        drv_if(0, 1'b1, 5'h04);
        drv_d(0, 1'b1, 1'b0, 5'h0A, 5'h00);
        exp_stb(0, 1'b0, 5'h04, 12'h000, t + 1);
        exp_ack(0, 0, 12'h123, t + 3);
        exp_stb(0, 1'b0, 5'h0A, 12'h000, t + 5);
        exp_ack(0, 1, 12'h013, t + 7);
        wait_ack(0, 0);
        drv_if(0, 1'b0, 5'h00);
        wait_ack(0, 1);
        drv_if(0, 1'b1, 5'h10);
        drv_d(0, 1'b1, 1'b0, 5'h06, 5'h00);
        exp_stb(0, 1'b0, 5'h10, 12'h000, t + 9);
        exp_ack(0, 0, 12'h7E8, t + 11);
        exp_stb(0, 1'b0, 5'h06, 12'h000, t + 13);
        exp_ack(0, 1, 12'h01C, t + 15);
        wait_ack(0, 0);
        drv_if(0, 1'b0, 5'h00);
        wait_ack(0, 1);
        drv_d(0, 1'b0, 1'b0, 5'h00, 5'h00);

        // Store: zero-extended write data, d_rdata keeps the last load (5'h1C).
        tick(1);
        t = cyc;
        drv_d(0, 1'b1, 1'b1, 5'h1F, 5'h15);
        exp_stb(0, 1'b1, 5'h1F, 12'h015, t + 1);
        exp_ack(0, 1, 12'h01C, t + 3);
        wait_ack(0, 1);
        drv_d(0, 1'b0, 1'b0, 5'h00, 5'h00);

        // IF read with d_wr high but no D request: no write strobe.
        tick(1);
        t = cyc;
        drv_if(0, 1'b1, 5'h06);
        drv_d(0, 1'b0, 1'b1, 5'h1F, 5'h15);
        exp_stb(0, 1'b0, 5'h06, 12'h000, t + 1);
        exp_ack(0, 0, 12'hA5C, t + 3);
        wait_ack(0, 0);
        drv_if(0, 1'b0, 5'h00);
        drv_d(0, 1'b0, 1'b0, 5'h00, 5'h00);

        // Request dropped during ACCESS still completes.
        tick(1);
        t = cyc;
        drv_d(0, 1'b1, 1'b0, 5'h04, 5'h00);
        exp_stb(0, 1'b0, 5'h04, 12'h000, t + 1);
        exp_ack(0, 1, 12'h003, t + 3);
        tick(1);
        drv_d(0, 1'b0, 1'b0, 5'h00, 5'h00);
        wait_ack(0, 1);

        // Fixed priority: both held, IF wins every transaction.
        tick(1);
        t = cyc;
        drv_if(2, 1'b1, 5'h04);
        drv_d(2, 1'b1, 1'b0, 5'h0A, 5'h00);
        for (int i = 0; i < 4; i++) begin
            exp_stb(2, 1'b0, 5'h04, 12'h000, t + 1 + 4 * i);
            exp_ack(2, 0, 12'h123, t + 3 + 4 * i);
        end
        for (int i = 0; i < 4; i++) wait_ack(2, 0);
        drv_if(2, 1'b0, 5'h00);
        drv_d(2, 1'b0, 1'b0, 5'h00, 5'h00);

        tick(6);
        chk("ackq_left", 32'(ackq.size()), 32'd0);
        chk("stbq_left", 32'(stbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
